password_stream_tx: RTL and testbench

Byte-stream transmitter on the source side of the password-checking datapath. It buffers a password written one character at a time, then on command streams it out byte by byte over a valid/ready interface with an end-of-password flag. Its output drives the per-character classifiers and the checker FSM. Benches and on-board stimulus use it as the single producer of the checker's character stream.

---
 rtl/pwd_stream_pkg.sv | 16 +
 rtl/password_stream_tx_if.sv | 25 ++
 rtl/pwd_char_buffer.sv | 25 ++
 rtl/password_stream_tx.sv | 115 +++++++++++
 tb/tb_password_stream_tx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwd_stream_pkg.sv
// Shared types and defaults for the password character stream.
// Imported by the transmitter and by the checker side of the datapath.
package pwd_stream_pkg;

  localparam int unsigned PWD_CHAR_W  = 8;
  localparam int unsigned PWD_MAX_LEN = 16;

  typedef logic [PWD_CHAR_W-1:0] char_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/password_stream_tx_if.sv
// Valid/ready character stream with an end-of-password flag.
interface password_stream_tx_if #(
  parameter int unsigned CHAR_W = 8
) ();

  logic              out_valid;
  logic [CHAR_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pwd_char_buffer.sv
// Character store: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; only the pointers around it are.
module pwd_char_buffer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/password_stream_tx.sv
// Buffers a password one character at a time, then streams it out on command
// as valid/ready beats with out_last on the final character.
module password_stream_tx
  import pwd_stream_pkg::*;
#(
  parameter int unsigned MAX_LEN = PWD_MAX_LEN,
  parameter int unsigned CHAR_W  = PWD_CHAR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [CHAR_W-1:0]            wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic                         err_overflow,
  output logic                         err_busy,
  password_stream_tx_if.master         out_if
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned PW = $clog2(MAX_LEN);

  state_e          state_q;
  logic [LW-1:0]   len_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            err_overflow_q;
  logic            err_busy_q;

  logic            is_idle;
  logic            is_send;
  logic            has_room;
  logic            wr_ok;
  logic            last_beat;
  logic [CHAR_W-1:0] rdata;

  assign is_idle   = (state_q == StIdle);
  assign is_send   = (state_q == StSend);
  assign has_room  = (len_q < LW'(MAX_LEN));
  assign wr_ok     = is_idle && wr_en && has_room;
  assign last_beat = is_send && (LW'(rd_ptr_q) == (len_q - LW'(1)));

  pwd_char_buffer #(
    .Depth (MAX_LEN),
    .Width (CHAR_W)
  ) u_buffer (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (len_q[PW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      len_q          <= '0;
      rd_ptr_q       <= '0;
      err_overflow_q <= 1'b0;
      err_busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_ok) begin
            len_q <= len_q + LW'(1);
          end
          if (start) begin
            err_overflow_q <= 1'b0;
            err_busy_q     <= 1'b0;
            rd_ptr_q       <= '0;
            // A write landing on the start edge is part of the password.
            state_q        <= ((len_q == '0) && !wr_ok) ? StDone : StSend;
          end
          // A dropped write on the start edge is still reported.
          if (wr_en && !has_room) begin
            err_overflow_q <= 1'b1;
          end
        end
        StSend: begin
          if (out_if.out_ready) begin
            if (last_beat) begin
              state_q <= StDone;
            end else begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
            end
          end
          if (wr_en || start) begin
            err_busy_q <= 1'b1;
          end
        end
        StDone: begin
          len_q   <= '0;
          state_q <= StIdle;
          if (wr_en || start) begin
            err_busy_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = !is_idle;
  assign done         = (state_q == StDone);
  assign len          = len_q;
  assign err_overflow = err_overflow_q;
  assign err_busy     = err_busy_q;

  assign out_if.out_valid = is_send;
  assign out_if.out_data  = is_send ? rdata : '0;
  assign out_if.out_last  = last_beat;

endmodule

// File: tb/tb_password_stream_tx.sv
// Scoreboard bench for password_stream_tx: written characters are queued as
// expected beats and popped by a monitor whenever a transfer occurs.
module tb_password_stream_tx;

  localparam int unsigned MaxLen = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] len;
  logic       err_overflow;
  logic       err_busy;

  password_stream_tx_if #(.CHAR_W(8)) out_if ();

  password_stream_tx #(
    .MAX_LEN (MaxLen),
    .CHAR_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .len          (len),
    .err_overflow (err_overflow),
    .err_busy     (err_busy),
    .out_if       (out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int mlen = 0;

  logic       stall_q = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  // Monitor: scoreboard pops on every transfer, and stalled beats must hold.
  always @(negedge clk) begin
    logic [7:0] exp_c;
    logic       exp_last;
    if (rst_n) begin
      if (stall_q) begin
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== prev_data ||
            out_if.out_last !== prev_last) begin
          failures++;
          $display("FAIL stall_hold valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   out_if.out_valid, out_if.out_data, out_if.out_last, prev_data, prev_last);
        end
      end
      if (out_if.out_valid && done) begin
        checks++;
        failures++;
        $display("FAIL done_with_valid done=%b valid=%b required valid=0", done, out_if.out_valid);
      end
      if (out_if.out_valid && out_if.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected data=%h required=no beat", out_if.out_data);
        end else begin
          exp_last = (exp_q.size() == 1);
          exp_c    = exp_q.pop_front();
          if (out_if.out_data !== exp_c || out_if.out_last !== exp_last) begin
            failures++;
            $display("FAIL beat data=%h last=%b required data=%h last=%b",
                     out_if.out_data, out_if.out_last, exp_c, exp_last);
          end
        end
      end
      stall_q   = out_if.out_valid && !out_if.out_ready;
      prev_data = out_if.out_data;
      prev_last = out_if.out_last;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] c);
    wr_en   = 1'b1;
    wr_data = c;
    if (mlen < MaxLen) begin
      exp_q.push_back(c);
      mlen++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done after a start edge; pattern drives out_ready per cycle.
  task automatic run_stream(input int n, input logic [3:0] pattern, input bit timed);
    int cyc = 0;
    for (int k = 1; k <= 200 && cyc == 0; k++) begin
      @(negedge clk);
      if (done) cyc = k;
      if (timed && k <= n + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_during_stream cycle=%0d busy=%b required=1", k, busy);
        end
      end
      @(posedge clk);
      #1;
      out_if.out_ready = pattern[k % 4];
    end
    checks++;
    if (cyc == 0) begin
      failures++;
      $display("FAIL done_timeout cycles=200 required=done pulse");
    end else if (timed && cyc != n + 1) begin
      failures++;
      $display("FAIL done_cycle got=%0d required=%0d", cyc, n + 1);
    end
    @(negedge clk);
    checks++;
    if (len !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_stream len=%0d busy=%b done=%b pending=%0d required 0 0 0 0",
               len, busy, done, exp_q.size());
    end
    mlen = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy, done, out_if.out_valid, out_if.out_last, err_overflow, err_busy} !== 6'b0 ||
        len !== 5'd0 || out_if.out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b valid=%b last=%b ovf=%b ebusy=%b len=%0d data=%h required all 0",
               busy, done, out_if.out_valid, out_if.out_last, err_overflow, err_busy, len,
               out_if.out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    put_str("abc");
    checks++;
    if (len !== 5'd3) begin
      failures++;
      $display("FAIL basic_len got=%0d required=3", len);
    end
    do_start();
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== "a") begin
      failures++;
      $display("FAIL first_beat_latency valid=%b data=%h required valid=1 data=61",
               out_if.out_valid, out_if.out_data);
    end
    run_stream(3, 4'b1111, 1'b1);
  endtask

  task automatic test_stall();
    put_str("pass");
    out_if.out_ready = 1'b1;
    do_start();
    run_stream(4, 4'b1001, 1'b0);
    out_if.out_ready = 1'b1;
  endtask

  task automatic test_empty();
    do_start();
    run_stream(0, 4'b1111, 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) put(8'h41 + 8'(i));
    checks++;
    if (len !== 5'd16 || err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow len=%0d ovf=%b required len=16 ovf=1", len, err_overflow);
    end
    do_start();
    run_stream(16, 4'b1111, 1'b1);
    do_start();
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear ovf=%b required=0", err_overflow);
    end
    run_stream(0, 4'b1111, 1'b1);
  endtask

  task automatic test_busy_err();
    put_str("xy");
    out_if.out_ready = 1'b0;
    do_start();
    wr_en = 1'b1;
    wr_data = "Z";
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    checks++;
    if (err_busy !== 1'b1 || len !== 5'd2) begin
      failures++;
      $display("FAIL busy_err ebusy=%b len=%0d required ebusy=1 len=2", err_busy, len);
    end
    out_if.out_ready = 1'b1;
    run_stream(2, 4'b1111, 1'b0);
  endtask

  task automatic test_same_cycle();
    put("q");
    wr_en = 1'b1;
    wr_data = "r";
    exp_q.push_back("r");
    mlen++;
    do_start();
    wr_en = 1'b0;
    checks++;
    if (err_busy !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_busy_err ebusy=%b required=0", err_busy);
    end
    run_stream(2, 4'b1111, 1'b1);
  endtask

  task automatic test_reset_mid();
    put_str("secret");
    do_start();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_if.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || len !== 5'd0) begin
      failures++;
      $display("FAIL reset_abort valid=%b done=%b busy=%b len=%0d required 0 0 0 0",
               out_if.out_valid, done, busy, len);
    end
    exp_q.delete();
    mlen = 0;
    tick();
    rst_n = 1'b1;
    tick();
    put_str("ok");
    checks++;
    if (len !== 5'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_write len=%0d busy=%b required len=2 busy=0", len, busy);
    end
    do_start();
    run_stream(2, 4'b1111, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_overflow();
    test_busy_err();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
